// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio serial path.
package audio_pkg;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned MCLK_BIT = 1;
    localparam int unsigned SCK_BIT  = 3;
    localparam int unsigned LRCK_BIT = 9;
    localparam int unsigned PHASE_W  = 4;
    localparam int unsigned SLOT_LSB = 4;
    localparam int unsigned SLOT_W   = 5;
    localparam int unsigned LEVEL_W  = 5;
    localparam int unsigned LEVEL_SHIFT = 6;

    localparam logic [PHASE_W-1:0] SAMPLE_PHASE = 4'd7;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ARM  = 2'd1,
        CAP_RUN  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter and registered MCLK/SCK/LRCK derived from it.
module i2s_clk_gen
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             audio_mclk,
    output logic             audio_sck,
    output logic             audio_lrck
);

    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);

    // Clock outputs take the next count so they stay bit-aligned with cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            audio_mclk <= cnt_nxt[MCLK_BIT];
            audio_sck  <= cnt_nxt[SCK_BIT];
            audio_lrck <= cnt_nxt[LRCK_BIT];
        end
    end

endmodule

// File: rtl/i2s_line_in.sv
// I2S master receiver: captures left/right ADC samples and a peak-level meter.
module i2s_line_in
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    input  logic              audio_sdout,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    output logic [LEVEL_W-1:0] led_level
);

    localparam logic [DATA_W-1:0] NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [CNT_W-1:0]   cnt;
    logic [SLOT_W-1:0]  slot;
    logic               sample_pt;
    logic               frame_end;
    logic               in_slot;
    logic               last_slot;
    logic               shift_en;
    logic               sd_q;
    logic [DATA_W-1:0]  shift_q;
    logic [DATA_W-1:0]  left_hold;
    logic [DATA_W-1:0]  cap_word;
    logic [DATA_W-1:0]  mag_l;
    logic [DATA_W-1:0]  mag_r;
    logic [DATA_W-1:0]  mag;
    logic [LEVEL_W-1:0] level_c;
    logic               capture;
    cap_state_e         state, state_nxt;

    i2s_clk_gen u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck)
    );

    assign slot      = cnt[SLOT_LSB +: SLOT_W];
    assign sample_pt = (cnt[PHASE_W-1:0] == SAMPLE_PHASE);
    assign frame_end = (cnt == {CNT_W{1'b1}});
    assign in_slot   = (slot != '0) && (slot <= SLOT_W'(DATA_W));
    assign last_slot = (slot == SLOT_W'(DATA_W));
    assign shift_en  = capture && sample_pt && in_slot;
    assign cap_word  = {shift_q[DATA_W-2:0], sd_q};

    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
        if (!x[DATA_W-1]) return x;
        if (x == NEG_FULL) return MAG_MAX;
        return DATA_W'(-x);
    endfunction

    // Thresholds rise monotonically, so the per-threshold bits form a thermometer.
    always_comb begin
        mag_l   = sat_abs(left_hold);
        mag_r   = sat_abs(cap_word);
        mag     = (mag_l > mag_r) ? mag_l : mag_r;
        level_c = '0;
        for (int k = 0; k < int'(LEVEL_W); k++) begin
            level_c[k] = (mag >= (DATA_W'(1) << (DATA_W - LEVEL_SHIFT + k)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CAP_IDLE;
        else      state <= state_nxt;
    end

    // Capture only starts on a frame boundary and stops as soon as en drops.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            CAP_IDLE: if (en) state_nxt = CAP_ARM;
            CAP_ARM: begin
                if (!en)            state_nxt = CAP_IDLE;
                else if (frame_end) state_nxt = CAP_RUN;
            end
            CAP_RUN: begin
                if (!en) state_nxt = CAP_IDLE;
                else     capture   = 1'b1;
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sd_q         <= 1'b0;
            shift_q      <= '0;
            left_hold    <= '0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            led_level    <= '0;
        end else begin
            sd_q         <= audio_sdout;
            sample_valid <= 1'b0;
            if (shift_en) begin
                shift_q <= cap_word;
                if (last_slot) begin
                    if (!cnt[LRCK_BIT]) begin
                        left_hold <= cap_word;
                    end else begin
                        sample_left  <= left_hold;
                        sample_right <= cap_word;
                        sample_valid <= 1'b1;
                        led_level    <= level_c;
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2s_line_in.md
# i2s_line_in

I2S master receiver for the line-in ADC on the audio Pmod. It is the capture-side counterpart of the `speaker_control` playback path. It generates its own MCLK/LRCK/SCK, deserializes `audio_sdout` into signed left/right samples, and emits one `sample_valid` pulse per stereo frame. A peak-level thermometer is provided for the LED volume meter. It sits beside `speaker_control` in the top level, clocked directly from the crystal clock.

## Interface
- `DATA_W`, 16: captured sample width, two's complement; legal range 8..31.
- `clk`  in  1: 100 MHz crystal clock; the only clock.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: capture enable. Serial clocks keep running when low.
- `audio_mclk`  out  1: ADC master clock, clk/4.
- `audio_lrck`  out  1: frame clock, clk/1024. Low = left channel.
- `audio_sck`  out  1: serial bit clock, clk/16; 64 SCK per frame.
- `audio_sdout`  in  1: serial data from ADC; ADC drives it on SCK falling edge.
- `sample_left`  out  DATA_W: last complete left sample.
- `sample_right`  out  DATA_W: last complete right sample, paired with `sample_left`.
- `sample_valid`  out  1: 1-clk pulse; a new left/right pair is on the outputs.
- `led_level`  out  5: thermometer peak meter of the last pair.

## Operation
- **Counter `cnt`**
  - Free-running 10-bit, +1 every clk, wraps 1023→0.
  - `audio_mclk` = `cnt[1]`, `audio_sck` = `cnt[3]`, `audio_lrck` = `cnt[9]`, all registered from `cnt`.
- **Input register and slot numbering**
  - `audio_sdout` is registered once per clk into `sd_q`.
  - Slot `s` = `cnt[8:4]` (0..31) within each LRCK half.
  - Sample point: the clk edge where `cnt[3:0]` == 7, i.e. the edge on which SCK rises. `sd_q` is captured there.
  - Standard I2S one-bit delay: slot 0 is ignored. Slots 1..DATA_W carry MSB..LSB, shifted MSB-first into the shift register. Slots DATA_W+1..31 are ignored.
- **Channel latching**
  - Left half (`cnt[9]`=0): the sample point at slot DATA_W copies the completed shift value (including that bit) into the internal `left_hold`.
  - Right half: the sample point at slot DATA_W loads `sample_right` from the shift value and `sample_left` from `left_hold`, both on the same edge. `sample_valid` = 1 for exactly that following cycle.
- **Enable: FSM `IDLE` → `ARM` → `RUN`**
  - `IDLE`: no capture. Outputs hold.
  - `IDLE`→`ARM` when `en`=1.
  - `ARM`→`RUN` on the clk where `cnt` wraps to 0, so only whole frames are captured.
  - `RUN`→`IDLE` immediately when `en`=0. A partially captured frame is discarded and no pulse is produced.
  - `ARM`→`IDLE` if `en`=0.
- **Level meter**
  - Updated on the same edge as `sample_valid`.
  - `mag` = max(|L|, |R|). |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1.
  - Level n = count of thresholds met: mag ≥ 2^(DATA_W−6+k), k = 0..4.
  - `led_level` = n ones right-aligned: 0→00000, 3→00111, 5→11111.
- **Reset**
  - Reset values: `cnt`=0, state `IDLE`, shift/hold=0, all outputs 0 (`audio_mclk`, `audio_lrck`, `audio_sck` low).
  - Reset mid-frame aborts capture with no pulse. After release, capture restarts at the next frame boundary following `en`.

## Timing
- Serial clocks: MCLK 25 MHz; SCK 6.25 MHz (8 clk high / 8 clk low); LRCK 97.656 kHz.
- First frame after reset release with `en`=1 throughout: `sample_valid` at `cnt`=0x308 of the first frame following the first wrap in `ARM`.
- Frame cadence: one `sample_valid` per 1024 clks, at `cnt`=0x308.
- Outputs are stable for the 1023 clks between pulses.
- Input latency: an `audio_sdout` bit must be stable during the clk cycle before the sampling edge (`sd_q` register stage).
- `en` falling on the pulse cycle itself: the pulse still completes; no further pulses.

## Structure
- Package `audio_pkg`:
  - Counter width 10.
  - Bit indices MCLK_BIT=1, SCK_BIT=3, LRCK_BIT=9.
  - SAMPLE_PHASE=4'd7.
  - Enable-FSM state enum.
- Sub-module `i2s_clk_gen`: the counter plus registered MCLK/SCK/LRCK outputs. Exports `cnt` for slot decode. `speaker_control` may later share it.

## Test plan
- Reset held low, then released: all outputs 0, then SCK toggles every 8 clk and LRCK every 512 clk.
- ADC model sends L=16'h1234, R=16'hFEDC with the 1-bit delay, `en`=1 → `sample_valid` at `cnt`=0x308; `sample_left`=16'h1234, `sample_right`=16'hFEDC; one pulse per 1024 clk.
- `en` raised mid-frame (`cnt`=0x150) → no pulse in that frame; first pulse at 0x308 of the next frame.
- `en` dropped at `cnt`=0x200 → no pulse at 0x308; outputs keep the previous pair.
- L=16'h8000, R=16'h0400 → `led_level`=11111. L=16'h0C00, R=16'hF801 → mag 0x0C00 → `led_level`=00011.
- `rst` asserted at `cnt`=0x305 → all outputs 0 immediately; no pulse until a full frame after release.
